rv32i_int_execute_unit: RTL and testbench

- Execute-stage integer datapath of the multi-cycle RV32I core.
- Three parallel units share one set of operand inputs from decode/register read:
  - register-register ALU (OP opcode),
  - register-immediate ALU (OP-IMM opcode),
  - AUIPC adder.
- All three results and the two ALU decoding-error flags are registered once and consumed by the writeback rd mux.

---
 rtl/rv32i_int_execute_unit.sv | 103 ++++++++++
 tb/tb_rv32i_int_execute_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_int_execute_unit.sv
// Execute-stage integer datapath: R-type ALU, I-type ALU and AUIPC adder computed
// in parallel from shared operands, with all results registered once for writeback.
module rv32i_int_execute_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [2:0]      subfunction_3,
   input  logic [6:0]      subfunction_7,
   input  logic [XLEN-1:0] input_register1_value,
   input  logic [XLEN-1:0] input_register2_value,
   input  logic [XLEN-1:0] immediate,
   input  logic [XLEN-1:0] program_counter,
   output logic [XLEN-1:0] rtype_result,
   output logic            rtype_decoding_error,
   output logic [XLEN-1:0] itype_result,
   output logic            itype_decoding_error,
   output logic [XLEN-1:0] auipc_result
);

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [XLEN-1:0] rs1, rs2, imm;
   logic [4:0]      r_shamt, i_shamt;
   logic [6:0]      imm_hi;
   logic [XLEN-1:0] r_res, i_res, a_res;
   logic            r_err, i_err;

   assign rs1     = input_register1_value;
   assign rs2     = input_register2_value;
   assign imm     = immediate;
   assign r_shamt = rs2[4:0];
   assign i_shamt = imm[4:0];
   assign imm_hi  = imm[11:5];
   assign a_res   = program_counter + imm;

   // Only funct7=0100000 with ADD/SUB or SRL/SRA selects the alternate op; all
   // other funct3 values require funct7=0.
   always_comb begin
      r_res = '0;
      r_err = 1'b0;
      if (subfunction_7 == F7_BASE) begin
         case (subfunction_3)
            3'b000: r_res = rs1 + rs2;
            3'b001: r_res = rs1 << r_shamt;
            3'b010: r_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            3'b011: r_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            3'b100: r_res = rs1 ^ rs2;
            3'b101: r_res = rs1 >> r_shamt;
            3'b110: r_res = rs1 | rs2;
            default: r_res = rs1 & rs2;
         endcase
      end else if (subfunction_7 == F7_ALT && subfunction_3 == 3'b000) begin
         r_res = rs1 - rs2;
      end else if (subfunction_7 == F7_ALT && subfunction_3 == 3'b101) begin
         r_res = $unsigned($signed(rs1) >>> r_shamt);
      end else begin
         r_err = 1'b1;
      end
   end

   // imm[11:5] only matters for the shift encodings; elsewhere it is immediate data.
   always_comb begin
      i_res = '0;
      i_err = 1'b0;
      case (subfunction_3)
         3'b000: i_res = rs1 + imm;
         3'b010: i_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(imm)};
         3'b011: i_res = {{(XLEN-1){1'b0}}, rs1 < imm};
         3'b100: i_res = rs1 ^ imm;
         3'b110: i_res = rs1 | imm;
         3'b111: i_res = rs1 & imm;
         3'b001: begin
            if (imm_hi == F7_BASE) i_res = rs1 << i_shamt;
            else                   i_err = 1'b1;
         end
         default: begin
            if (imm_hi == F7_BASE)     i_res = rs1 >> i_shamt;
            else if (imm_hi == F7_ALT) i_res = $unsigned($signed(rs1) >>> i_shamt);
            else                       i_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rtype_result         <= '0;
         rtype_decoding_error <= 1'b0;
         itype_result         <= '0;
         itype_decoding_error <= 1'b0;
         auipc_result         <= '0;
      end else if (enable) begin
         rtype_result         <= r_res;
         rtype_decoding_error <= r_err;
         itype_result         <= i_res;
         itype_decoding_error <= i_err;
         auipc_result         <= a_res;
      end
   end

endmodule

// File: tb/tb_rv32i_int_execute_unit.sv
// Self-checking bench: directed vector table, stall/reset sequences, and random
// stimulus checked against an arithmetic reference model.
module tb_rv32i_int_execute_unit;

   logic        clk = 1'b0;
   logic        reset, enable;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] rs1, rs2, imm, pc;
   logic [31:0] rtype_result, itype_result, auipc_result;
   logic        rtype_decoding_error, itype_decoding_error;

   int total = 0;
   int bad   = 0;

   // model state (expected registered outputs)
   logic [31:0] m_r = '0, m_i = '0, m_a = '0;
   logic        m_re = 1'b0, m_ie = 1'b0;

   rv32i_int_execute_unit #(.XLEN(32)) dut (
      .clk                  (clk),
      .reset                (reset),
      .enable               (enable),
      .subfunction_3        (f3),
      .subfunction_7        (f7),
      .input_register1_value(rs1),
      .input_register2_value(rs2),
      .immediate            (imm),
      .program_counter      (pc),
      .rtype_result         (rtype_result),
      .rtype_decoding_error (rtype_decoding_error),
      .itype_result         (itype_result),
      .itype_decoding_error (itype_decoding_error),
      .auipc_result         (auipc_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] rs1, rs2, imm, pc;
      int          unit;   // 0 = R-type, 1 = I-type, 2 = AUIPC
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain signed/unsigned integer arithmetic, shifts as powers of two.
   function automatic logic [31:0] calc(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint pw = longint'(1) << b[4:0];
      longint r;
      case (op)
         3'd0: r = alt ? ua - ub : ua + ub;
         3'd1: r = ua * pw;
         3'd2: r = (sa < sb) ? 1 : 0;
         3'd3: r = (ua < ub) ? 1 : 0;
         3'd4: r = ua ^ ub;
         3'd5: r = !alt ? ua / pw : (sa >= 0 ? sa / pw : -((-sa + pw - 1) / pw));
         3'd6: r = ua | ub;
         default: r = ua & ub;
      endcase
      return r[31:0];
   endfunction

   function automatic void model_next();
      logic r_legal, i_legal, r_alt, i_alt;
      logic [6:0] hi;
      if (reset) begin
         m_r = '0; m_i = '0; m_a = '0; m_re = 1'b0; m_ie = 1'b0;
         return;
      end
      if (!enable) return;
      r_alt   = (f7 == 7'h20);
      r_legal = (f7 == 7'h00) || (r_alt && (f3 == 3'd0 || f3 == 3'd5));
      hi      = imm[11:5];
      i_alt   = (f3 == 3'd5) && (hi == 7'h20);
      i_legal = (f3 == 3'd1) ? (hi == 7'h00) :
                (f3 == 3'd5) ? (hi == 7'h00 || hi == 7'h20) : 1'b1;
      m_re = !r_legal;
      m_r  = r_legal ? calc(f3, r_alt, rs1, rs2) : 32'h0;
      m_ie = !i_legal;
      m_i  = i_legal ? calc(f3, i_alt, rs1, imm) : 32'h0;
      m_a  = pc + imm;
   endfunction

   // One clock edge; model advances on the same edge, outputs sampled 1ns later.
   task automatic step();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".r"},   rtype_result, m_r);
      chk({tag, ".re"},  {31'b0, rtype_decoding_error}, {31'b0, m_re});
      chk({tag, ".i"},   itype_result, m_i);
      chk({tag, ".ie"},  {31'b0, itype_decoding_error}, {31'b0, m_ie});
      chk({tag, ".a"},   auipc_result, m_a);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".r"},  rtype_result, 32'h0);
      chk({tag, ".re"}, {31'b0, rtype_decoding_error}, 32'h0);
      chk({tag, ".i"},  itype_result, 32'h0);
      chk({tag, ".ie"}, {31'b0, itype_decoding_error}, 32'h0);
      chk({tag, ".a"},  auipc_result, 32'h0);
   endtask

   task automatic drive(input logic [2:0] a3, input logic [6:0] a7, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] ai, input logic [31:0] ap);
      f3 = a3; f7 = a7; rs1 = a1; rs2 = a2; imm = ai; pc = ap;
   endtask

   task automatic drive_rand();
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0, 1: f7 = 7'h00;
         2:    f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      rs1 = $urandom;
      rs2 = $urandom;
      case ($urandom_range(0, 3))
         0: imm = {{20{1'b0}}, 7'h00, 5'($urandom)};
         1: imm = {{20{1'b0}}, 7'h20, 5'($urandom)};
         2: imm = {$urandom} & 32'hFFFF_F000;
         default: imm = $urandom;
      endcase
      pc = $urandom;
   endtask

   function automatic vec_t mk(input string n, input logic [2:0] a3, input logic [6:0] a7,
                               input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] ai,
                               input logic [31:0] ap, input int u, input logic [31:0] e,
                               input logic er);
      vec_t v;
      v.name = n; v.f3 = a3; v.f7 = a7; v.rs1 = a1; v.rs2 = a2; v.imm = ai; v.pc = ap;
      v.unit = u; v.exp = e; v.err = er;
      return v;
   endfunction

   initial begin
      logic [31:0] act;
      logic        act_err;

      vecs.push_back(mk("add_ovf",  3'd0, 7'h00, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 0, 32'h80000000, 1'b0));
      vecs.push_back(mk("sub",      3'd0, 7'h20, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 0, 32'h7FFFFFFE, 1'b0));
      vecs.push_back(mk("sub_wrap", 3'd0, 7'h20, 32'h0,        32'h1, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 1'b0));
      vecs.push_back(mk("sra",      3'd5, 7'h20, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'hF8000000, 1'b0));
      vecs.push_back(mk("srl",      3'd5, 7'h00, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'h08000000, 1'b0));
      vecs.push_back(mk("sll",      3'd1, 7'h00, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'h00000000, 1'b0));
      vecs.push_back(mk("slt",      3'd2, 7'h00, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'h1, 1'b0));
      vecs.push_back(mk("sltu",     3'd3, 7'h00, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'h0, 1'b0));
      vecs.push_back(mk("r_bad_f7", 3'd0, 7'h01, 32'h80000000, 32'h4, 32'h0, 32'h0, 0, 32'h0, 1'b1));
      vecs.push_back(mk("sll31",    3'd1, 7'h00, 32'h00000001, 32'h1F, 32'h0, 32'h0, 0, 32'h80000000, 1'b0));
      vecs.push_back(mk("addi",     3'd0, 7'h00, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 32'h4, 1'b0));
      vecs.push_back(mk("slti",     3'd2, 7'h00, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1'b0));
      vecs.push_back(mk("sltiu",    3'd3, 7'h00, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 32'h1, 1'b0));
      vecs.push_back(mk("xori",     3'd4, 7'h00, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 32'hFFFFFFFA, 1'b0));
      vecs.push_back(mk("andi",     3'd7, 7'h00, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 32'h5, 1'b0));
      vecs.push_back(mk("srai",     3'd5, 7'h55, 32'h80000000, 32'h0, 32'h401, 32'h0, 1, 32'hC0000000, 1'b0));
      vecs.push_back(mk("slli_bad", 3'd1, 7'h00, 32'h80000000, 32'h0, 32'h421, 32'h0, 1, 32'h0, 1'b1));
      vecs.push_back(mk("srli0",    3'd5, 7'h00, 32'h80000001, 32'h0, 32'h0, 32'h0, 1, 32'h80000001, 1'b0));
      vecs.push_back(mk("auipc",    3'd0, 7'h00, 32'h0, 32'h0, 32'h12345000, 32'h10, 2, 32'h12345010, 1'b0));
      vecs.push_back(mk("auipc_wr", 3'd0, 7'h00, 32'h0, 32'h0, 32'h00002000, 32'hFFFFF000, 2, 32'h00001000, 1'b0));

      // reset with random inputs, then idle with enable low
      reset = 1'b1; enable = 1'b1;
      drive_rand();
      step(); chk_zero("reset1");
      drive_rand();
      step(); chk_zero("reset2");
      reset = 1'b0; enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_rand();
         step(); chk_zero("idle");
      end

      // directed table
      enable = 1'b1;
      foreach (vecs[n]) begin
         drive(vecs[n].f3, vecs[n].f7, vecs[n].rs1, vecs[n].rs2, vecs[n].imm, vecs[n].pc);
         step();
         case (vecs[n].unit)
            0: begin act = rtype_result; act_err = rtype_decoding_error; end
            1: begin act = itype_result; act_err = itype_decoding_error; end
            default: begin act = auipc_result; act_err = vecs[n].err; end
         endcase
         chk(vecs[n].name, act, vecs[n].exp);
         if (vecs[n].unit != 2) chk({vecs[n].name, ".err"}, {31'b0, act_err}, {31'b0, vecs[n].err});
      end

      // stall: load ADD, change inputs with enable low, then re-enable
      enable = 1'b1;
      drive(3'd0, 7'h00, 32'h00000003, 32'h00000004, 32'h00000100, 32'h00001000);
      step(); chk("stall_load", rtype_result, 32'h7);
      enable = 1'b0;
      drive(3'd0, 7'h00, 32'h00000010, 32'h00000020, 32'h00000200, 32'h00002000);
      step(); chk("stall_hold1", rtype_result, 32'h7); chk("stall_hold1.a", auipc_result, 32'h1100);
      step(); chk("stall_hold2", rtype_result, 32'h7); chk("stall_hold2.i", itype_result, 32'h103);
      enable = 1'b1;
      step(); chk("stall_resume", rtype_result, 32'h30); chk("stall_resume.a", auipc_result, 32'h2200);

      // reset beats enable, then release with enable high captures next edge
      reset = 1'b1;
      step(); chk_zero("rst_en");
      reset = 1'b0;
      step(); chk("rst_release", rtype_result, 32'h30); chk("rst_release.i", itype_result, 32'h210);

      // random stimulus against the model
      for (int k = 0; k < 400; k++) begin
         drive_rand();
         reset  = ($urandom_range(0, 19) == 0);
         enable = ($urandom_range(0, 3) != 0);
         step();
         chk_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
